// File: rtl/nibble_scatter.sv
// nibble_scatter
// Scatters the nibble lanes of each accepted input beat into chosen positions
// of a wide output word. The word is offered downstream once every position
// has been written, or earlier on a flush, and is held until it is taken.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : input beat valid
//   in_ready   : block can accept a beat (low while a word is held)
//   data_in    : LANES nibbles, lane i at [DATA_WIDTH*i +: DATA_WIDTH]
//   wDest      : per lane 5-bit field {dest[3:0], enable}
//   flush      : offer the partially filled word
//   data_out   : assembled word, position p at [DATA_WIDTH*p +: DATA_WIDTH]
//   fill_mask  : positions written since the last emit
//   out_valid  : assembled word offered
//   out_ready  : downstream takes the word
//   wBusy      : a word is held (same as out_valid)
//   err        : sticky collision flag, cleared only by reset
//
// state | meaning
// IDLE  | no position written yet
// FILL  | some positions written, word not yet complete
// HOLD  | word offered on data_out, waiting for out_ready
module nibble_scatter #(
  parameter int DATA_WIDTH = 4,
  parameter int LANES      = 4,
  parameter int POSITIONS  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]      data_in,
  input  logic [LANES*5-1:0]               wDest,
  input  logic                             flush,
  output logic [POSITIONS*DATA_WIDTH-1:0]  data_out,
  output logic [POSITIONS-1:0]             fill_mask,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             wBusy,
  output logic                             err
);

  localparam int FIELD_W = 5;
  localparam int DEST_W  = 4;
  localparam int OUT_W   = POSITIONS * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                 state;
  logic [OUT_W-1:0]       dataReg;
  logic [POSITIONS-1:0]   maskReg;
  logic                   errReg;

  logic [OUT_W-1:0]       nextData;
  logic [POSITIONS-1:0]   nextMask;
  logic [POSITIONS-1:0]   mergedMask;
  logic                   collision;
  logic                   anyEnable;
  logic                   hit;
  logic                   accept;
  logic                   commit;

  assign accept = in_valid && in_ready;
  assign commit = accept && anyEnable;

  // Lanes are visited in ascending order so a higher lane overwrites a lower
  // one aimed at the same position. A lane collides if its position was
  // already filled by an earlier beat or by a lower lane of this beat.
  always_comb begin
    nextData  = dataReg;
    nextMask  = maskReg;
    collision = 1'b0;
    anyEnable = 1'b0;
    hit       = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      anyEnable = anyEnable | wDest[i*FIELD_W];
    end
    for (int p = 0; p < POSITIONS; p++) begin
      hit = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        if (wDest[i*FIELD_W] && (wDest[i*FIELD_W+1 +: DEST_W] == DEST_W'(p))) begin
          if (hit || maskReg[p]) begin
            collision = 1'b1;
          end
          nextData[p*DATA_WIDTH +: DATA_WIDTH] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
          hit = 1'b1;
        end
      end
      if (hit) begin
        nextMask[p] = 1'b1;
      end
    end
  end

  // Mask as it will stand after this edge; drives the IDLE/FILL/HOLD choice
  // so a flush arriving with a beat still includes that beat.
  assign mergedMask = commit ? nextMask : maskReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dataReg <= '0;
      maskReg <= '0;
      errReg  <= 1'b0;
    end else begin
      case (state)
        IDLE, FILL: begin
          if (commit) begin
            dataReg <= nextData;
            maskReg <= nextMask;
            errReg  <= errReg | collision;
          end
          if ((&mergedMask) || (flush && (|mergedMask))) begin
            state <= HOLD;
          end else if (|mergedMask) begin
            state <= FILL;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (out_ready) begin
            dataReg <= '0;
            maskReg <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign data_out  = dataReg;
  assign fill_mask = maskReg;
  assign out_valid = (state == HOLD);
  assign wBusy     = (state == HOLD);
  assign in_ready  = (state != HOLD);
  assign err       = errReg;

endmodule

// File: doc/nibble_scatter.md
NIBBLE_SCATTER -- requirements
Module: nibble_scatter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, nibble width in bits.
REQ-002 SHALL have parameter LANES, default 4, nibble lanes per input beat.
REQ-003 SHALL have parameter POSITIONS, default 16, nibble positions in the assembled output word.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, the input beat is valid.
REQ-007 SHALL have port in_ready, output, 1, the block can accept a beat.
REQ-008 SHALL have port data_in, input, LANES*DATA_WIDTH (16), lane i = data_in[4i+3:4i].
REQ-009 SHALL have port wDest, input, LANES*5 (20), lane i field = wDest[5i+4:5i]; bit 0 = lane enable, bits 4:1 = destination position.
REQ-010 SHALL have port flush, input, 1, emit the partially filled word.
REQ-011 SHALL have port data_out, output, POSITIONS*DATA_WIDTH (64), assembled word; position p = data_out[4p+3:4p].
REQ-012 SHALL have port fill_mask, output, POSITIONS (16), positions written since the last emit.
REQ-013 SHALL have port out_valid, output, 1, data_out is complete and offered.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts data_out.
REQ-015 SHALL have port wBusy, output, 1, high while a word is held; upstream selectors stall on it.
REQ-016 SHALL have port err, output, 1, sticky collision flag.

Function
REQ-017 SHALL implement FSM states IDLE (fill_mask zero), FILL (fill_mask nonzero, not full), HOLD (word offered).
REQ-018 SHALL drive in_ready = 1 in IDLE and FILL and 0 in HOLD; a beat is accepted when in_valid && in_ready at the clock edge.
REQ-019 On acceptance, for each enabled lane SHALL write that lane's nibble into its destination position and set the matching fill_mask bit; disabled lanes SHALL change nothing.
REQ-020 When two enabled lanes in one beat target the same position, the higher-numbered lane SHALL win and err SHALL set.
REQ-021 When an enabled lane targets a position whose fill_mask bit is already set, SHALL overwrite the nibble and set err.
REQ-022 An accepted beat with no enabled lane SHALL leave data_out, fill_mask, and state unchanged.
REQ-023 When the updated fill_mask equals all ones, SHALL enter HOLD; out_valid and wBusy SHALL be high from the cycle after the completing edge (one-cycle latency).
REQ-024 flush sampled high in FILL SHALL enter HOLD on that edge; unwritten positions SHALL read 0.
REQ-025 flush and an accepted beat on the same edge SHALL include the beat's nibbles in the held word.
REQ-026 flush in IDLE with no enabled lane accepted SHALL be ignored; flush in HOLD SHALL be ignored.
REQ-027 In HOLD, data_out and fill_mask SHALL stay stable until out_valid && out_ready.
REQ-028 On the out_ready edge SHALL clear data_out and fill_mask to 0 and go to IDLE; in_ready SHALL be high the next cycle.
REQ-029 out_valid SHALL equal wBusy and be high only in HOLD.
REQ-030 err SHALL stay set until reset.

Reset
REQ-031 rst high at a rising edge SHALL force IDLE, data_out=0, fill_mask=0, out_valid=0, wBusy=0, err=0, and in_ready=1 from the next cycle.
REQ-032 rst SHALL take priority over every event in the same cycle, including a held word, a flush, or an accepted beat.

Verification
REQ-033 4 beats, lanes all enabled, positions 0..15 in order, data_in = 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC -> out_valid one cycle after the 4th edge, data_out=64'hFEDCBA9876543210, err=0.
REQ-034 out_ready held 0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0 and data_out stable; out_ready=1 -> IDLE and fill_mask=0 next cycle.
REQ-035 one beat writing positions 0..3 with 16'hABCD, then flush -> data_out=64'h000000000000ABCD, fill_mask=16'h000F.
REQ-036 beat with lanes 0 and 2 both targeting position 5 (nibbles 1 and 9) -> position 5 = 9, err=1, and err still 1 after the word is emitted.
REQ-037 rst asserted in HOLD with out_ready=0 -> all outputs at reset values next cycle and no word emitted.
REQ-038 flush in IDLE, then beat with all lanes disabled -> no state change and out_valid stays 0.
